alu_exec_unit: RTL and testbench

//  Execute-stage ALU. Sits directly downstream of the ALU decoder and consumes its 3-bit alucontrol code.

---
 rtl/alu_exec_unit.sv | 113 +++++++++++
 tb/tb_alu_exec_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative one-bit-per-cycle shifts,
// behind valid/ready handshakes on both the operand and result sides.
//
// state | meaning
// IDLE  | no result held, ready for an operation
// SHIFT | iterating a shift, one bit position per cycle
// DONE  | result held, out_valid=1 until consumed
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alucontrol,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work;
   logic [SHW-1:0]   cnt;
   logic             dir_right;
   logic             accept;
   logic             is_shift;
   logic [SHW-1:0]   shamt;
   logic             start_shift;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] work_nxt;
   logic             shift_last;

   assign accept      = in_valid & in_ready;
   assign is_shift    = (alucontrol == 3'b100) | (alucontrol == 3'b101);
   assign shamt       = src_b[SHW-1:0];
   assign start_shift = is_shift & (shamt != '0);
   assign work_nxt    = dir_right ? (work >> 1) : (work << 1);
   assign shift_last  = (state == SHIFT) & (cnt == SHW'(1));

   // A zero-distance shift is passed straight through as a single-cycle op.
   always_comb begin
      alu_res = '0;
      case (alucontrol)
         3'b000:  alu_res = src_a & src_b;
         3'b001:  alu_res = src_a | src_b;
         3'b010:  alu_res = src_a + src_b;
         3'b011:  alu_res = src_a ^ src_b;
         3'b100:  alu_res = src_a;
         3'b101:  alu_res = src_a;
         3'b110:  alu_res = src_a - src_b;
         default: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) state_nxt = start_shift ? SHIFT : DONE;
         end
         SHIFT: begin
            if (cnt == SHW'(1)) state_nxt = DONE;
         end
         DONE: begin
            if (accept)         state_nxt = start_shift ? SHIFT : DONE;
            else if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result    <= '0;
         zero      <= 1'b0;
         work      <= '0;
         cnt       <= '0;
         dir_right <= 1'b0;
      end else if (accept) begin
         if (start_shift) begin
            work      <= src_a;
            cnt       <= shamt;
            dir_right <= alucontrol[0];
         end else begin
            result <= alu_res;
            zero   <= (alu_res == '0);
         end
      end else if (state == SHIFT) begin
         work <= work_nxt;
         cnt  <= cnt - SHW'(1);
         if (shift_last) begin
            result <= work_nxt;
            zero   <= (work_nxt == '0);
         end
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    alucontrol = 3'b000;
   logic [W-1:0]  src_a = '0;
   logic [W-1:0]  src_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          zero;

   int vecs = 0;
   int errs = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alucontrol(alucontrol), .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int sh;
      longint sa, sb;
      sh = int'(b % W);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return W'((64'(a) + 64'(b)) % (64'd1 << W));
         3'd3: return a ^ b;
         3'd4: return a << sh;
         3'd5: return a >> sh;
         3'd6: return W'((64'(a) + (64'd1 << W) - 64'(b)) % (64'd1 << W));
         default: return (sa < sb) ? W'(1) : W'(0);
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
      if ((op == 3'd4 || op == 3'd5) && (b % W) != 0) return int'(b % W) + 1;
      return 1;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op from IDLE, wait for the result, check it, then consume it.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
      int lat;
      @(negedge clk);
      check({tag, " in_ready"}, W'(in_ready), W'(1));
      in_valid = 1'b1; alucontrol = op; src_a = a; src_b = b; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; alucontrol = 3'($urandom); src_a = $urandom; src_b = $urandom;
      lat = 1;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         check({tag, " in_ready_busy"}, W'(in_ready), W'(0));
         lat++;
         if (lat > 80) begin
            check({tag, " timeout"}, W'(out_valid), W'(1));
            break;
         end
      end
      check({tag, " latency"}, W'(lat), W'(ref_lat(op, b)));
      check({tag, " result"}, result, exp);
      check({tag, " zero"}, W'(zero), W'(exp == '0));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, " idle"}, W'(out_valid), W'(0));
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b;

      #12;
      check("rst out_valid", W'(out_valid), W'(0));
      check("rst result", result, W'(0));
      check("rst zero", W'(zero), W'(0));
      @(negedge clk); rst_n = 1'b1;

      // back-to-back: ADD then SUB accepted in the DONE cycle
      @(negedge clk);
      in_valid = 1'b1; alucontrol = 3'd2; src_a = 5; src_b = 7; out_ready = 1'b1;
      @(posedge clk); #1;
      alucontrol = 3'd6; src_a = 9; src_b = 9;
      @(negedge clk);
      check("b2b add valid", W'(out_valid), W'(1));
      check("b2b add result", result, W'(12));
      check("b2b add zero", W'(zero), W'(0));
      check("b2b in_ready", W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b sub valid", W'(out_valid), W'(1));
      check("b2b sub result", result, W'(0));
      check("b2b sub zero", W'(zero), W'(1));
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk);
      check("b2b idle", W'(out_valid), W'(0));

      do_op("slt", 3'd7, 32'hFFFF_FFFF, 32'd1, 32'd1);
      do_op("and", 3'd0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
      do_op("or",  3'd1, 32'h1200_0034, 32'h0056_7800, 32'h1256_7834);
      do_op("xor", 3'd3, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00);
      do_op("sll4", 3'd4, 32'd1, 32'd4, 32'h10);
      do_op("srl31", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1);
      do_op("sll0", 3'd4, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF);
      do_op("sll_out", 3'd4, 32'h8000_0000, 32'd1, 32'd0);
      do_op("add_wrap", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'd1);

      // backpressure: result held while out_ready is low, new requests refused
      @(negedge clk);
      in_valid = 1'b1; alucontrol = 3'd2; src_a = 1; src_b = 1; out_ready = 1'b0;
      @(posedge clk); #1;
      alucontrol = 3'd1; src_a = 32'hFF; src_b = 32'hF00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp valid", W'(out_valid), W'(1));
         check("bp result", result, W'(2));
         check("bp in_ready", W'(in_ready), W'(0));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      @(negedge clk);
      check("bp idle", W'(out_valid), W'(0));

      // reset in the middle of a 20-step shift
      @(negedge clk);
      in_valid = 1'b1; alucontrol = 3'd5; src_a = 32'hF000_0000; src_b = 20;
      @(posedge clk); #1; in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b0; #1;
      check("mid rst valid", W'(out_valid), W'(0));
      repeat (2) begin
         @(negedge clk);
         check("in rst valid", W'(out_valid), W'(0));
      end
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         check("post rst no result", W'(out_valid), W'(0));
      end
      check("post rst in_ready", W'(in_ready), W'(1));
      do_op("post rst add", 3'd2, 32'd3, 32'd4, 32'd7);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         if (i % 4 == 0) b = b & 32'h7;
         if (i % 5 == 0) a = b;
         do_op("rand", op, a, b, ref_op(op, a, b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
